mby_mesh_data_pack: RTL and testbench

Upstream packer for the mesh data bus. It accepts a stream of 64-bit words with valid/ready handshake and packs eight consecutive words into one 512-bit mesh data beat. Packets shorter than a whole beat are closed early on end-of-packet, with zero fill and a word count. Completed beats are buffered in a small FIFO, and the FIFO head is presented to the mesh data master driver.

---
 rtl/mby_mesh_data_pack.sv | 99 +++++++++
 tb/tb_mby_mesh_data_pack.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mby_mesh_data_pack.sv
// Packs IN_W-bit words into OUT_W-bit mesh beats, closing early on end-of-packet,
// and buffers completed beats in a small circular FIFO ahead of the mesh master.
module mby_mesh_data_pack #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 512,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_eop,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [OUT_W-1:0] out_data,
  output logic [3:0]       out_nwords,
  output logic             out_eop,
  input  logic             out_rdy,
  output logic [15:0]      beat_cnt
);

  localparam int LANES = OUT_W / IN_W;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [2:0]       idx_p0;
  logic [OUT_W-1:0] asm_p0;
  logic [OUT_W-1:0] merged;

  logic [OUT_W-1:0] fifo_data   [DEPTH];
  logic [3:0]       fifo_nwords [DEPTH];
  logic             fifo_eop    [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic accept;
  logic close;
  logic pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_rdy  = rst && (count < CW'(DEPTH));
  assign accept  = in_vld && in_rdy;
  assign close   = accept && ((idx_p0 == 3'(LANES - 1)) || in_eop);
  assign out_vld = rst && (count != '0);
  assign pop     = out_vld && out_rdy;

  // Slots above idx are still zero from the last clear, so a short beat is zero-filled.
  always_comb begin
    merged = asm_p0;
    for (int k = 0; k < LANES; k++) begin
      if (idx_p0 == 3'(k)) merged[k*IN_W +: IN_W] = in_data;
    end
  end

  // Stage p0: accumulator and FIFO control
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_p0   <= '0;
      asm_p0   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
    end else begin
      if (close) begin
        idx_p0 <= '0;
        asm_p0 <= '0;
        wr_ptr <= next_ptr(wr_ptr);
      end else if (accept) begin
        idx_p0 <= idx_p0 + 3'd1;
        asm_p0 <= merged;
      end
      if (pop) begin
        rd_ptr   <= next_ptr(rd_ptr);
        beat_cnt <= beat_cnt + 16'd1;
      end
      if (close && !pop)      count <= count + 1'b1;
      else if (!close && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (close) begin
      fifo_data[wr_ptr]   <= merged;
      fifo_nwords[wr_ptr] <= {1'b0, idx_p0} + 4'd1;
      fifo_eop[wr_ptr]    <= in_eop;
    end
  end

  // Stage p1: FIFO head, forced to zero when empty or in reset
  assign out_data   = out_vld ? fifo_data[rd_ptr]   : '0;
  assign out_nwords = out_vld ? fifo_nwords[rd_ptr] : 4'd0;
  assign out_eop    = out_vld ? fifo_eop[rd_ptr]    : 1'b0;

endmodule

// File: tb/tb_mby_mesh_data_pack.sv
// Scoreboard bench for mby_mesh_data_pack: a word-level model queues expected
// beats on accept and a negedge monitor compares them as beats are popped.
module tb_mby_mesh_data_pack;

  logic         clk;
  logic         rst;
  logic         in_vld;
  logic [63:0]  in_data;
  logic         in_eop;
  logic         in_rdy;
  logic         out_vld;
  logic [511:0] out_data;
  logic [3:0]   out_nwords;
  logic         out_eop;
  logic         out_rdy;
  logic [15:0]  beat_cnt;

  mby_mesh_data_pack #(.IN_W(64), .OUT_W(512), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_eop(in_eop),
    .in_rdy(in_rdy), .out_vld(out_vld), .out_data(out_data), .out_nwords(out_nwords),
    .out_eop(out_eop), .out_rdy(out_rdy), .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic [3:0]   nw;
    logic         eop;
  } beat_t;

  beat_t        sb[$];
  logic [511:0] m_asm;
  int           m_idx;
  logic [15:0]  exp_pops;
  int           total;
  int           bad;

  logic         stall;
  logic [511:0] held_data;
  logic [3:0]   held_nw;
  logic         held_eop;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [63:0] d, input logic e);
    m_asm[m_idx*64 +: 64] = d;
    if (m_idx == 7 || e) begin
      sb.push_back('{data: m_asm, nw: 4'(m_idx + 1), eop: e});
      m_asm = '0;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_asm    = '0;
    m_idx    = 0;
    exp_pops = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send(input logic [63:0] d, input logic e);
    int n;
    n = 0;
    in_vld  = 1'b1;
    in_data = d;
    in_eop  = e;
    @(negedge clk);
    while (!in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) check("rdy_timeout", 0, 1);
    else model_accept(d, e);
    @(posedge clk);
    #1;
    in_vld  = 1'b0;
    in_eop  = 1'b0;
    in_data = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    check("drain_empty", 512'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_vld", 512'(out_vld), 1);
        check("hold_data", out_data, held_data);
        check("hold_nw", 512'(out_nwords), 512'(held_nw));
        check("hold_eop", 512'(out_eop), 512'(held_eop));
      end
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          beat_t b;
          b = sb.pop_front();
          check("sb_data", out_data, b.data);
          check("sb_nw", 512'(out_nwords), 512'(b.nw));
          check("sb_eop", 512'(out_eop), 512'(b.eop));
        end
        exp_pops = exp_pops + 16'd1;
      end
      stall     = out_vld && !out_rdy;
      held_data = out_data;
      held_nw   = out_nwords;
      held_eop  = out_eop;
    end
  end

  initial begin
    logic [511:0] exp_short;
    total   = 0;
    bad     = 0;
    stall   = 1'b0;
    rst     = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    in_eop  = 1'b0;
    out_rdy = 1'b1;
    model_clear();

    // Reset state
    tick();
    tick();
    check("rst_in_rdy", 512'(in_rdy), 0);
    check("rst_out_vld", 512'(out_vld), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_nw", 512'(out_nwords), 0);
    check("rst_beat_cnt", 512'(beat_cnt), 0);
    rst = 1'b1;
    #1;
    check("post_rst_in_rdy", 512'(in_rdy), 1);

    // Full beat with eop on the 8th word
    for (int k = 0; k < 7; k++) send(64'(k), 1'b0);
    check("full_vld_before", 512'(out_vld), 0);
    send(64'd7, 1'b1);
    check("full_vld_after", 512'(out_vld), 1);
    check("full_nw", 512'(out_nwords), 8);
    check("full_eop", 512'(out_eop), 1);
    check("full_lane3", 512'(out_data[3*64 +: 64]), 3);
    check("full_lane7", 512'(out_data[7*64 +: 64]), 7);
    tick();
    check("full_beat_cnt", 512'(beat_cnt), 1);
    check("full_vld_gone", 512'(out_vld), 0);

    // Short packet A,B,C
    send(64'hA, 1'b0);
    send(64'hB, 1'b0);
    send(64'hC, 1'b1);
    exp_short = {320'd0, 64'hC, 64'hB, 64'hA};
    check("short_nw", 512'(out_nwords), 3);
    check("short_eop", 512'(out_eop), 1);
    check("short_data", out_data, exp_short);
    drain();

    // Backpressure: two beats fill the FIFO, in_rdy drops, then release
    out_rdy = 1'b0;
    for (int i = 0; i < 16; i++) send(64'h100 + 64'(i), 1'b0);
    check("bp_in_rdy_low", 512'(in_rdy), 0);
    check("bp_out_vld", 512'(out_vld), 1);
    check("bp_head", out_data, sb[0].data);
    repeat (3) tick();
    check("bp_head_held", out_data, sb[0].data);
    out_rdy = 1'b1;
    #1;
    check("bp_no_comb_relief", 512'(in_rdy), 0);
    tick();
    check("bp_in_rdy_back", 512'(in_rdy), 1);
    for (int i = 16; i < 24; i++) send(64'h100 + 64'(i), 1'b0);
    drain();
    check("bp_beat_cnt", 512'(beat_cnt), 512'(exp_pops));

    // Simultaneous push and pop with one beat buffered
    out_rdy = 1'b0;
    send(64'h55, 1'b1);
    send(64'h60, 1'b0);
    out_rdy = 1'b1;
    send(64'h61, 1'b1);
    out_rdy = 1'b0;
    #1;
    check("pp_vld", 512'(out_vld), 1);
    check("pp_in_rdy", 512'(in_rdy), 1);
    check("pp_head_nw", 512'(out_nwords), 2);
    check("pp_head_lane1", 512'(out_data[64 +: 64]), 64'h61);
    out_rdy = 1'b1;
    drain();

    // Reset mid-operation: one beat buffered plus a 5-word partial
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) send(64'hD0 + 64'(i), 1'b0);
    for (int i = 0; i < 5; i++) send(64'hE0 + 64'(i), 1'b0);
    rst = 1'b0;
    #1;
    check("mr_in_rdy", 512'(in_rdy), 0);
    check("mr_vld_during", 512'(out_vld), 0);
    tick();
    check("mr_vld", 512'(out_vld), 0);
    check("mr_data", out_data, 0);
    check("mr_nw", 512'(out_nwords), 0);
    check("mr_eop", 512'(out_eop), 0);
    check("mr_beat_cnt", 512'(beat_cnt), 0);
    rst = 1'b1;
    model_clear();
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send(64'hF0 + 64'(i), 1'b0);
    drain();
    check("mr_beat_cnt_after", 512'(beat_cnt), 1);

    // beat_cnt wrap over 65537 single-word packets
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 65537; i++) send(64'(i), 1'b1);
    drain();
    check("wrap_beat_cnt", 512'(beat_cnt), 16'h0001);
    check("wrap_model_cnt", 512'(beat_cnt), 512'(exp_pops));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
